bit_serial_tx: RTL and testbench

BIT_SERIAL_TX -- requirements
Module: bit_serial_tx

---
 rtl/bit_serial_tx.sv | 130 +++++++++++++
 tb/tb_bit_serial_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_tx.sv
// Byte-to-serial transmitter: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Optional parity bit enabled by defining BIT_SERIAL_TX_PARITY_EN.
module bit_serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       inClk,
  input  logic       inRst,
  input  logic [7:0] inData,
  input  logic       inValid,
  output logic       outReady,
  output logic       outTx,
  output logic       outBusy,
  output logic       outDone
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic ONE_CYCLE = (CLKS_PER_BIT == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef BIT_SERIAL_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             w_bit_end;

  assign w_bit_end = (r_cnt == CNT_LAST);

  // Frame sequencer; outDone is raised on the edge that enters the last STOP cycle.
  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE) begin
        r_cnt <= w_bit_end ? '0 : r_cnt + CNT_W'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (inValid) begin
            r_shift <= inData;
            r_state <= S_START;
            r_tx    <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_bit   <= '0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            // Rotation leaves the latched byte intact after eight bits.
            r_bit   <= r_bit + 3'd1;
            r_shift <= {r_shift[0], r_shift[7:1]};
            if (r_bit == 3'd7) begin
`ifdef BIT_SERIAL_TX_PARITY_EN
              r_state <= S_PARITY;
              r_tx    <= ^r_shift;
`else
              r_state <= S_STOP;
              r_tx    <= 1'b1;
              r_done  <= ONE_CYCLE;
`endif
            end else begin
              r_tx <= r_shift[1];
            end
          end
        end
`ifdef BIT_SERIAL_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
            r_done  <= ONE_CYCLE;
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else if (!ONE_CYCLE && (r_cnt == CNT_PRE)) begin
            r_done <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign outReady = r_ready;
  assign outTx    = r_tx;
  assign outBusy  = r_busy;
  assign outDone  = r_done;

endmodule

// File: tb/tb_bit_serial_tx.sv
// Directed bench for bit_serial_tx: three instances with CLKS_PER_BIT = 4, 2 and 1.
module tb_bit_serial_tx;

`ifdef BIT_SERIAL_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic       clk;
  logic       rst;
  logic [2:0] valid;
  logic [2:0] ready;
  logic [2:0] tx;
  logic [2:0] busy;
  logic [2:0] done;
  logic [7:0] data [3];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bit_serial_tx #(.CLKS_PER_BIT((g == 0) ? 4 : ((g == 1) ? 2 : 1))) u_dut (
      .inClk   (clk),
      .inRst   (rst),
      .inData  (data[g]),
      .inValid (valid[g]),
      .outReady(ready[g]),
      .outTx   (tx[g]),
      .outBusy (busy[g]),
      .outDone (done[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level for bit period idx of a frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 1 && idx <= 8) return b[idx-1];
`ifdef BIT_SERIAL_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Sends one byte and checks every cycle of the frame; optionally pulses a stray request at cycle inject.
  task automatic drive_frame(input int d, input int n, input logic [7:0] b, input int inject, input string tag);
    logic exp_tx;
    logic exp_done;
    @(negedge clk);
    valid[d] = 1'b1;
    data[d]  = b;
    total++;
    if (ready[d] !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_before_handshake got=%b want=1", tag, ready[d]);
    end
    @(posedge clk);
    @(negedge clk);
    data[d] = ~b;
    for (int j = 1; j <= FL * n; j++) begin
      if (j > 1) @(negedge clk);
      exp_tx   = frame_bit(b, (j - 1) / n);
      exp_done = (j == FL * n);
      total++;
      if (tx[d] !== exp_tx || done[d] !== exp_done || busy[d] !== 1'b1 || ready[d] !== 1'b0) begin
        bad++;
        $display("FAIL %s cyc=%0d tx=%b/%b done=%b/%b busy=%b/1 ready=%b/0",
                 tag, j, tx[d], exp_tx, done[d], exp_done, busy[d], ready[d]);
      end
      valid[d] = (j == inject);
      if (j == inject) data[d] = 8'h3C;
    end
    valid[d] = 1'b0;
    @(negedge clk);
    total++;
    if (ready[d] !== 1'b1 || busy[d] !== 1'b0 || tx[d] !== 1'b1 || done[d] !== 1'b0) begin
      bad++;
      $display("FAIL %s idle_after ready=%b/1 busy=%b/0 tx=%b/1 done=%b/0",
               tag, ready[d], busy[d], tx[d], done[d]);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    valid = 3'b000;
    for (int d = 0; d < 3; d++) data[d] = 8'h00;
    #2;
    for (int d = 0; d < 3; d++) begin
      total++;
      if (tx[d] !== 1'b1 || ready[d] !== 1'b1 || busy[d] !== 1'b0 || done[d] !== 1'b0) begin
        bad++;
        $display("FAIL reset dut=%0d tx=%b/1 ready=%b/1 busy=%b/0 done=%b/0",
                 d, tx[d], ready[d], busy[d], done[d]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_frame();
    drive_frame(0, 4, 8'hA5, 0, "basic_a5");
  endtask

  task automatic test_parity_bits();
    drive_frame(0, 4, 8'h01, 0, "parity_01");
    drive_frame(0, 4, 8'hFE, 0, "parity_fe");
  endtask

  task automatic test_ignored_request();
    drive_frame(0, 4, 8'h96, 17, "ignored_req");
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      total++;
      if (busy[0] !== 1'b0 || tx[0] !== 1'b1 || ready[0] !== 1'b1) begin
        bad++;
        $display("FAIL no_extra_frame cyc=%0d busy=%b/0 tx=%b/1 ready=%b/1", c, busy[0], tx[0], ready[0]);
      end
    end
  endtask

  task automatic test_abort();
    logic exp_tx;
    @(negedge clk);
    valid[0] = 1'b1;
    data[0]  = 8'hC3;
    @(posedge clk);
    for (int j = 1; j <= 18; j++) begin
      @(negedge clk);
      valid[0] = 1'b0;
      exp_tx = frame_bit(8'hC3, (j - 1) / 4);
      total++;
      if (tx[0] !== exp_tx || busy[0] !== 1'b1) begin
        bad++;
        $display("FAIL abort_pre cyc=%0d tx=%b/%b busy=%b/1", j, tx[0], exp_tx, busy[0]);
      end
    end
    rst = 1'b1;
    #1;
    total++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || ready[0] !== 1'b1 || done[0] !== 1'b0) begin
      bad++;
      $display("FAIL abort_async tx=%b/1 busy=%b/0 ready=%b/1 done=%b/0", tx[0], busy[0], ready[0], done[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_frame(0, 4, 8'h5A, 0, "abort_resend");
  endtask

  task automatic test_back_to_back();
    int gap;
    gap = 0;
    @(negedge clk);
    valid[1] = 1'b1;
    data[1]  = 8'hFF;
    total++;
    if (ready[1] !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ready got=%b want=1", ready[1]);
    end
    @(posedge clk);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) data[1] = 8'h00;
      if (ready[1] === 1'b1) begin
        gap = c;
        break;
      end
      total++;
      if (tx[1] !== frame_bit(8'hFF, (c - 1) / 2)) begin
        bad++;
        $display("FAIL b2b_first cyc=%0d tx=%b want=%b", c, tx[1], frame_bit(8'hFF, (c - 1) / 2));
      end
    end
    total++;
    if (gap != 2 * FL + 1) begin
      bad++;
      $display("FAIL b2b_spacing got=%0d want=%0d", gap, 2 * FL + 1);
    end
    @(posedge clk);
    for (int j = 1; j <= FL * 2; j++) begin
      @(negedge clk);
      if (j == 1) valid[1] = 1'b0;
      total++;
      if (tx[1] !== frame_bit(8'h00, (j - 1) / 2) || busy[1] !== 1'b1) begin
        bad++;
        $display("FAIL b2b_second cyc=%0d tx=%b/%b busy=%b/1", j, tx[1], frame_bit(8'h00, (j - 1) / 2), busy[1]);
      end
    end
    valid[1] = 1'b0;
    @(negedge clk);
    total++;
    if (ready[1] !== 1'b1 || busy[1] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle ready=%b/1 busy=%b/0", ready[1], busy[1]);
    end
  endtask

  task automatic test_min_divider();
    drive_frame(2, 1, 8'h80, 0, "min_div_80");
    drive_frame(2, 1, 8'h3B, 0, "min_div_3b");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_parity_bits();
    test_ignored_request();
    test_abort();
    test_back_to_back();
    test_min_divider();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
